// File: rtl/aes_dec_key_feeder.sv
// AES-128 decrypt round-key feeder: byte-serial key load, forward expansion, reverse-order byte-serial serving.
// Define AES_DEC_EQKEY_EN to store InvMixColumns(round keys 9..1) for the equivalent inverse cipher.
module aes_dec_key_feeder #(
  parameter int NR          = 10,
  parameter bit AUTO_REWIND = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in_valid,
  input  logic [7:0] key_in,
  input  logic       rk_req,
  output logic       busy,
  output logic       keys_ready,
  output logic       rk_valid,
  output logic [7:0] rk_byte,
  output logic [3:0] rk_round,
  output logic       rk_last
);

  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] LAST_WORD = 6'(4 * NR + 3);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXPAND, S_READY, S_SEND} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Forward S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] b;
    y = x;
    for (int k = 0; k < 6; k++) y = gf_mul(gf_mul(y, y), x);
    b = gf_mul(y, y);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

`ifdef AES_DEC_EQKEY_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction
`endif

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [5:0]    word_q, word_d;
  logic [3:0]    round_q, round_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [127:0]  win_q, win_d;
  logic [31:0]   ks_q [0:NW-1];
  logic [31:0]   ks_d [0:NW-1];
  logic [31:0]   new_word, store_word, rd_word;

  logic          busy_q, busy_d;
  logic          keys_ready_q, keys_ready_d;
  logic          rk_valid_q, rk_valid_d;
  logic [7:0]    rk_byte_q, rk_byte_d;
  logic [3:0]    rk_round_q, rk_round_d;
  logic          rk_last_q, rk_last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      word_q       <= 6'd0;
      round_q      <= 4'd0;
      rcon_q       <= 8'h00;
      win_q        <= '0;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_byte_q    <= 8'h00;
      rk_round_q   <= 4'd0;
      rk_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      win_q        <= win_d;
      busy_q       <= busy_d;
      keys_ready_q <= keys_ready_d;
      rk_valid_q   <= rk_valid_d;
      rk_byte_q    <= rk_byte_d;
      rk_round_q   <= rk_round_d;
      rk_last_q    <= rk_last_d;
    end
  end

  // Store contents are meaningless until an expansion completes, so no reset.
  always_ff @(posedge clk) begin
    ks_q <= ks_d;
  end

  // win_q holds the last four raw words w[i-4..i-1]; the store may hold transformed words.
  always_comb begin
    new_word = win_q[127:96] ^ ((word_q[1:0] == 2'b00)
             ? (sub_word({win_q[23:0], win_q[31:24]}) ^ {rcon_q, 24'h000000})
             : win_q[31:0]);
`ifdef AES_DEC_EQKEY_EN
    store_word = (word_q < 6'(4 * NR)) ? inv_mix_col(new_word) : new_word;
`else
    store_word = new_word;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    win_d   = win_q;
    ks_d    = ks_q;
    case (state_q)
      S_IDLE, S_READY: begin
        if (key_in_valid) begin
          state_d = S_LOAD;
          win_d   = {win_q[119:0], key_in};
          cnt_d   = 4'd1;
        end else if (state_q == S_READY && rk_req) begin
          state_d = S_SEND;
          cnt_d   = 4'd0;
        end
      end
      S_LOAD: begin
        if (key_in_valid) begin
          win_d = {win_q[119:0], key_in};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_EXPAND;
            word_d  = 6'd4;
            rcon_d  = 8'h01;
            for (int k = 0; k < 4; k++) ks_d[k] = win_d[127 - 32 * k -: 32];
          end
        end
      end
      S_EXPAND: begin
        win_d         = {win_q[95:0], new_word};
        ks_d[word_q]  = store_word;
        if (word_q[1:0] == 2'b00) rcon_d = xtime(rcon_q);
        if (word_q == LAST_WORD) begin
          state_d = S_READY;
          round_d = 4'(NR);
          word_d  = 6'd0;
        end else begin
          word_d = word_q + 6'd1;
        end
      end
      S_SEND: begin
        if (cnt_q == 4'd15) begin
          cnt_d = 4'd0;
          if (round_q != 4'd0) begin
            round_d = round_q - 4'd1;
            state_d = S_READY;
          end else if (AUTO_REWIND) begin
            round_d = 4'(NR);
            state_d = S_READY;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so rk_valid follows rk_req by exactly one cycle.
  always_comb begin
    rd_word      = ks_q[{round_q, cnt_d[3:2]}];
    busy_d       = (state_d == S_LOAD) || (state_d == S_EXPAND) || (state_d == S_SEND);
    keys_ready_d = (state_d == S_READY);
    rk_valid_d   = (state_d == S_SEND);
    rk_byte_d    = 8'h00;
    if (rk_valid_d) begin
      case (cnt_d[1:0])
        2'd0:    rk_byte_d = rd_word[31:24];
        2'd1:    rk_byte_d = rd_word[23:16];
        2'd2:    rk_byte_d = rd_word[15:8];
        default: rk_byte_d = rd_word[7:0];
      endcase
    end
    rk_round_d = rk_valid_d ? round_q : 4'd0;
    rk_last_d  = rk_valid_d && (cnt_d == 4'd15) && (round_q == 4'd0);
  end

  assign busy       = busy_q;
  assign keys_ready = keys_ready_q;
  assign rk_valid   = rk_valid_q;
  assign rk_byte    = rk_byte_q;
  assign rk_round   = rk_round_q;
  assign rk_last    = rk_last_q;

endmodule

// File: tb/tb_aes_dec_key_feeder.sv
// Directed bench for aes_dec_key_feeder using the FIPS-197 AES-128 key schedule.
module tb_aes_dec_key_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in_valid;
  logic [7:0] key_in;
  logic       rk_req;
  logic       busy;
  logic       keys_ready;
  logic       rk_valid;
  logic [7:0] rk_byte;
  logic [3:0] rk_round;
  logic       rk_last;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;

  aes_dec_key_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .key_in_valid (key_in_valid),
    .key_in       (key_in),
    .rk_req       (rk_req),
    .busy         (busy),
    .keys_ready   (keys_ready),
    .rk_valid     (rk_valid),
    .rk_byte      (rk_byte),
    .rk_round     (rk_round),
    .rk_last      (rk_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input int first, input bit gaps);
    for (int i = first; i < 16; i++) begin
      key_in_valid = 1'b1;
      key_in       = k[127 - 8 * i -: 8];
      tick();
      if (gaps) begin
        key_in_valid = 1'b0;
        tick();
      end
    end
    key_in_valid = 1'b0;
    key_in       = 8'h00;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!keys_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic get_round(output logic [127:0] data, output logic [3:0] rnd,
                           output int gaps, output int last_idx);
    data     = '0;
    rnd      = 4'hf;
    gaps     = 0;
    last_idx = -1;
    rk_req   = 1'b1;
    tick();
    rk_req   = 1'b0;
    for (int b = 0; b < 16; b++) begin
      if (!rk_valid) gaps++;
      data[127 - 8 * b -: 8] = rk_byte;
      rnd = rk_round;
      if (rk_last) last_idx = b;
      tick();
    end
  endtask

  initial begin
    logic [127:0] data;
    logic [3:0]   rnd;
    int           gaps;
    int           last_idx;
    int           n;
    int           bad;

    rst          = 1'b1;
    key_in_valid = 1'b0;
    key_in       = 8'h00;
    rk_req       = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy",       128'(busy),       128'(0));
    check("reset_keys_ready", 128'(keys_ready), 128'(0));
    check("reset_rk_valid",   128'(rk_valid),   128'(0));
    check("reset_rk_byte",    128'(rk_byte),    128'(0));
    check("reset_rk_round",   128'(rk_round),   128'(0));
    check("reset_rk_last",    128'(rk_last),    128'(0));

    // Gap-free load: the byte cycle is cycle 0, the tick after it cycle 1.
    load_key(KEY, 0, 1'b0);
    check("expand_busy", 128'(busy), 128'(1));
    n = 1;
    while (!keys_ready && n < 200) begin
      tick();
      n++;
    end
    check("ready_latency", 128'(n), 128'(41));

    for (int r = 10; r >= 0; r--) begin
      get_round(data, rnd, gaps, last_idx);
      check($sformatf("round%0d_index", r), 128'(rnd), 128'(r));
      check($sformatf("round%0d_gaps", r), 128'(gaps), 128'(0));
      check($sformatf("round%0d_last", r), 128'(last_idx), 128'((r == 0) ? 15 : -1));
      if (r == 10) check("round10_key", data, R10);
`ifndef AES_DEC_EQKEY_EN
      if (r == 1) check("round1_key", data, R1);
`endif
      if (r == 0) check("round0_key", data, KEY);
    end
    check("after_r0_ready", 128'(keys_ready), 128'(1));
    check("after_r0_valid", 128'(rk_valid), 128'(0));

    get_round(data, rnd, gaps, last_idx);
    check("rewind_index", 128'(rnd), 128'(10));
    check("rewind_key", data, R10);

    // Simultaneous key byte and request in READY: the load wins.
    rk_req       = 1'b1;
    key_in_valid = 1'b1;
    key_in       = KEY[127:120];
    tick();
    rk_req       = 1'b0;
    key_in_valid = 1'b0;
    check("abort_valid", 128'(rk_valid), 128'(0));
    check("abort_busy", 128'(busy), 128'(1));
    check("abort_ready", 128'(keys_ready), 128'(0));
    load_key(KEY, 1, 1'b0);
    wait_ready(n);
    check("abort_reload_ready", 128'(keys_ready), 128'(1));
    get_round(data, rnd, gaps, last_idx);
    check("abort_reload_key", data, R10);

    // Gapped load, with rk_req held high through the expansion.
    load_key(KEY, 0, 1'b1);
    rk_req = 1'b1;
    bad = 0;
    n = 0;
    while (!keys_ready && n < 200) begin
      tick();
      n++;
      if (rk_valid) bad++;
    end
    rk_req = 1'b0;
    check("expand_req_ignored", 128'(bad), 128'(0));
    check("gap_ready", 128'(keys_ready), 128'(1));
    tick();
    check("req_not_queued", 128'(rk_valid), 128'(0));
    get_round(data, rnd, gaps, last_idx);
    check("gap_round10_key", data, R10);
    check("gap_round10_index", 128'(rnd), 128'(10));
    get_round(data, rnd, gaps, last_idx);
    check("gap_round9_index", 128'(rnd), 128'(9));

    // Reset in the middle of round 10.
    for (int r = 8; r >= 0; r--) get_round(data, rnd, gaps, last_idx);
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    repeat (7) tick();
    check("send_byte7", 128'(rk_byte), 128'(8'h89));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rk_valid", 128'(rk_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_keys_ready", 128'(keys_ready), 128'(0));
    rk_req = 1'b1;
    bad = 0;
    repeat (3) begin
      tick();
      if (rk_valid) bad++;
    end
    rk_req = 1'b0;
    check("idle_req_ignored", 128'(bad), 128'(0));
    load_key(KEY, 0, 1'b0);
    wait_ready(n);
    check("post_rst_ready", 128'(keys_ready), 128'(1));
    get_round(data, rnd, gaps, last_idx);
    check("post_rst_round10", data, R10);
    check("post_rst_gaps", 128'(gaps), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
